// File: rtl/comp_mult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier among NREQ requesters.
// Issue order is kept in a tag FIFO so in-order results return to their owner.
module comp_mult_arbiter #(
    parameter int DWIDTH = 8,
    parameter int NREQ   = 4,
    parameter int TAG_AW = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sw_rst,
    input  logic [NREQ-1:0]             req_op_val,
    output logic [NREQ-1:0]             req_op_rdy,
    input  logic [NREQ*4*DWIDTH-1:0]    req_op_data,
    output logic [NREQ-1:0]             req_res_val,
    input  logic [NREQ-1:0]             req_res_rdy,
    output logic [4*(DWIDTH+1)-1:0]     req_res_data,
    output logic                        mul_op_val,
    input  logic                        mul_op_rdy,
    output logic [4*DWIDTH-1:0]         mul_op_data,
    input  logic                        mul_res_val,
    output logic                        mul_res_rdy,
    input  logic [4*(DWIDTH+1)-1:0]     mul_res_data,
    output logic [TAG_AW:0]             outstanding,
    output logic                        tag_err
);

    localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DEPTH = 2 ** TAG_AW;
    localparam logic [TAG_AW:0] FULL_CNT = (TAG_AW+1)'(DEPTH);

    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant, head;
    logic [TAG_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [TAG_AW:0]   cnt_q, cnt_d;
    logic              tag_err_q;
    logic [GW-1:0]     tag_mem_q [DEPTH];
    logic              live, full, empty, push, pop;

    // Handshakes are suppressed while either reset is active.
    assign live  = rst_n & ~sw_rst;
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign head  = tag_mem_q[rd_ptr_q];

    always_comb begin
        grant = rr_ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_op_val[idx]) grant = GW'(idx);
        end
    end

    assign mul_op_val  = live & (|req_op_val) & ~full;
    assign mul_op_data = req_op_data[grant*4*DWIDTH +: 4*DWIDTH];

    always_comb begin
        req_op_rdy  = '0;
        req_res_val = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_op_rdy[i]  = live & (grant == GW'(i)) & mul_op_rdy & ~full;
            req_res_val[i] = live & mul_res_val & ~empty & (head == GW'(i));
        end
    end

    assign mul_res_rdy  = live & ~empty & req_res_rdy[head];
    assign req_res_data = mul_res_data;

    assign push = mul_op_val & mul_op_rdy;
    assign pop  = mul_res_val & mul_res_rdy;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = (grant == GW'(NREQ-1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tag_err_q <= 1'b0;
        end else if (sw_rst) begin
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tag_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            tag_err_q <= tag_err_q | (mul_res_val & empty);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant;
    end

    assign outstanding = cnt_q;
    assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_comp_mult_arbiter.sv
// Directed bench for comp_mult_arbiter; the multiplier side is driven by hand.
module tb_comp_mult_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int TA = 3;

    logic              clk = 1'b0;
    logic              rst_n, sw_rst;
    logic [NR-1:0]     req_op_val, req_op_rdy;
    logic [NR*4*DW-1:0] req_op_data;
    logic [NR-1:0]     req_res_val, req_res_rdy;
    logic [4*(DW+1)-1:0] req_res_data;
    logic              mul_op_val, mul_op_rdy;
    logic [4*DW-1:0]   mul_op_data;
    logic              mul_res_val, mul_res_rdy;
    logic [4*(DW+1)-1:0] mul_res_data;
    logic [TA:0]       outstanding;
    logic              tag_err;

    logic [4*DW-1:0]   ops [NR];
    int                expq [$];
    int                n_checks = 0;
    int                n_errors = 0;

    assign req_op_data = {ops[3], ops[2], ops[1], ops[0]};

    comp_mult_arbiter #(.DWIDTH(DW), .NREQ(NR), .TAG_AW(TA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst       (sw_rst),
        .req_op_val   (req_op_val),
        .req_op_rdy   (req_op_rdy),
        .req_op_data  (req_op_data),
        .req_res_val  (req_res_val),
        .req_res_rdy  (req_res_rdy),
        .req_res_data (req_res_data),
        .mul_op_val   (mul_op_val),
        .mul_op_rdy   (mul_op_rdy),
        .mul_op_data  (mul_op_data),
        .mul_res_val  (mul_res_val),
        .mul_res_rdy  (mul_res_rdy),
        .mul_res_data (mul_res_data),
        .outstanding  (outstanding),
        .tag_err      (tag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] res1;
        int h;
        int j;
        bit stalled;

        ops[0] = 32'h03040506;
        ops[1] = 32'hF9020AFD;
        ops[2] = 32'h7F80017F;
        ops[3] = 32'h11223344;
        res1   = {18'h3FFF7, 18'h00026};

        rst_n = 1'b0; sw_rst = 1'b0;
        req_op_val = '0; req_res_rdy = '0;
        mul_op_rdy = 1'b0; mul_res_val = 1'b0; mul_res_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_tag_err", 64'(tag_err), 64'd0);
        check("rst_mul_op_val", 64'(mul_op_val), 64'd0);
        check("rst_req_op_rdy", 64'(req_op_rdy), 64'd0);
        check("rst_mul_res_rdy", 64'(mul_res_rdy), 64'd0);
        check("rst_req_res_val", 64'(req_res_val), 64'd0);
        rst_n = 1'b1;

        // Single op from req0, result two cycles later
        tick;
        req_op_val = 4'b0001; mul_op_rdy = 1'b1;
        #1;
        check("t1_mul_op_val", 64'(mul_op_val), 64'd1);
        check("t1_req_op_rdy", 64'(req_op_rdy), 64'b0001);
        check("t1_mul_op_data", 64'(mul_op_data), 64'(ops[0]));
        tick;
        req_op_val = '0;
        #1;
        check("t1_outstanding1", 64'(outstanding), 64'd1);
        tick;
        mul_res_val = 1'b1; mul_res_data = res1; req_res_rdy = 4'hF;
        #1;
        check("t1_req_res_val", 64'(req_res_val), 64'b0001);
        check("t1_mul_res_rdy", 64'(mul_res_rdy), 64'd1);
        check("t1_res_data", 64'(req_res_data), 64'(res1));
        tick;
        mul_res_val = 1'b0;
        #1;
        check("t1_outstanding0", 64'(outstanding), 64'd0);

        sw_rst = 1'b1;
        tick;
        sw_rst = 1'b0;

        // All four requesting: round-robin until the tag FIFO fills
        req_op_val = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t2_grant", 64'(req_op_rdy), 64'd1 << (k % 4));
            check("t2_op_data", 64'(mul_op_data), 64'(ops[k % 4]));
            expq.push_back(k % 4);
            tick;
        end
        #1;
        check("t3_outstanding_full", 64'(outstanding), 64'd8);
        check("t3_mul_op_val_full", 64'(mul_op_val), 64'd0);
        check("t3_req_op_rdy_full", 64'(req_op_rdy), 64'd0);

        // A pop while full does not unblock issue in the same cycle
        mul_res_val = 1'b1; mul_res_data = 36'd999;
        #1;
        check("t3_pop_owner", 64'(req_res_val), 64'd1 << expq[0]);
        check("t3_blocked_on_pop", 64'(mul_op_val), 64'd0);
        tick;
        void'(expq.pop_front());
        mul_res_val = 1'b0;
        #1;
        check("t3_resume_val", 64'(mul_op_val), 64'd1);
        check("t3_resume_grant", 64'(req_op_rdy), 64'b0001);
        expq.push_back(0);
        tick;
        req_op_val = '0;
        #1;
        check("t3_outstanding_refill", 64'(outstanding), 64'd8);

        // Drain in issue order with req2 back-pressuring for 5 cycles
        j = 0;
        stalled = 1'b0;
        while (expq.size() > 0) begin
            h = expq[0];
            mul_res_val = 1'b1;
            mul_res_data = 36'(1000 + j * 37);
            if (h == 2 && !stalled) begin
                req_res_rdy = 4'b1011;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    check("t4_stall_rdy", 64'(mul_res_rdy), 64'd0);
                    check("t4_stall_val", 64'(req_res_val), 64'b0100);
                    tick;
                end
                stalled = 1'b1;
                req_res_rdy = 4'hF;
            end
            #1;
            check("t4_res_owner", 64'(req_res_val), 64'd1 << h);
            check("t4_mul_res_rdy", 64'(mul_res_rdy), 64'd1);
            check("t4_res_data", 64'(req_res_data), 64'(1000 + j * 37));
            tick;
            void'(expq.pop_front());
            j++;
        end
        mul_res_val = 1'b0;
        #1;
        check("t4_outstanding0", 64'(outstanding), 64'd0);

        // Result with nothing outstanding
        mul_res_val = 1'b1; mul_res_data = 36'h123;
        #1;
        check("t5_mul_res_rdy", 64'(mul_res_rdy), 64'd0);
        check("t5_req_res_val", 64'(req_res_val), 64'd0);
        tick;
        mul_res_val = 1'b0;
        #1;
        check("t5_tag_err_set", 64'(tag_err), 64'd1);
        tick;
        #1;
        check("t5_tag_err_sticky", 64'(tag_err), 64'd1);
        sw_rst = 1'b1;
        tick;
        sw_rst = 1'b0;
        #1;
        check("t5_tag_err_clear", 64'(tag_err), 64'd0);

        // Async reset with three ops in flight
        req_op_val = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t6_grant", 64'(req_op_rdy), 64'd1 << k);
            tick;
        end
        req_op_val = '0;
        #1;
        check("t6_outstanding3", 64'(outstanding), 64'd3);
        rst_n = 1'b0;
        #1;
        check("t6_async_outstanding", 64'(outstanding), 64'd0);
        check("t6_rst_mul_op_val", 64'(mul_op_val), 64'd0);
        tick;
        rst_n = 1'b1;
        req_op_val = 4'hF;
        #1;
        check("t6_post_rst_grant", 64'(req_op_rdy), 64'b0001);
        check("t6_post_rst_data", 64'(mul_op_data), 64'(ops[0]));
        tick;
        req_op_val = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
